// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and default sizes for the SDRAM burst arbiter
//
// Purpose : FSM state and grant encodings plus default geometry constants.
// Ports   : none (package).
package sdram_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WRITE,
      RD_ISSUE,
      RD_DRAIN
   } state_t;

   typedef enum logic {
      GRANT_WR,
      GRANT_RD
   } grant_t;

   localparam int DEF_BURST_SIZE = 8;
   localparam int DEF_ADDR_WIDTH = 24;
   localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - round-robin write/read burst arbiter in front of one Avalon-MM SDRAM port
//
// Purpose : shares the SDRAM controller between the DVI capture write FIFO and
//           the LED refresh read path, alternating bursts when both are pending.
// Ports   : SDRAM_CLK/nReset            clock, async active-low reset
//           frameStart                  clears the write address
//           wrAvail/wrData/wrPop        show-ahead write FIFO head
//           rdReq/rdAddr/rdAddrAck      read burst request and command address
//           rdDataValid/rdData          returned read words
//           av*                         Avalon-MM master to the SDRAM controller
module sdram_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int BURST_SIZE = DEF_BURST_SIZE,
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
   input  logic                  SDRAM_CLK,
   input  logic                  nReset,
   input  logic                  frameStart,
   input  logic                  wrAvail,
   input  logic [DATA_WIDTH-1:0] wrData,
   output logic                  wrPop,
   input  logic                  rdReq,
   input  logic [ADDR_WIDTH-1:0] rdAddr,
   output logic                  rdAddrAck,
   output logic                  rdDataValid,
   output logic [DATA_WIDTH-1:0] rdData,
   output logic [ADDR_WIDTH-1:0] avAddress,
   output logic [DATA_WIDTH-1:0] avWriteData,
   output logic                  avWrite_n,
   output logic                  avRead_n,
   input  logic [DATA_WIDTH-1:0] avReadData,
   input  logic                  avReadDataValid,
   input  logic                  avWaitRequest
);

   localparam int CNT_W = $clog2(BURST_SIZE) + 1;
   localparam int WC_W  = $clog2(BURST_SIZE);

   localparam logic [CNT_W-1:0] BURST_C    = CNT_W'(BURST_SIZE);
   localparam logic [CNT_W-1:0] ISSUE_LAST = CNT_W'(BURST_SIZE - 1);
   localparam logic [WC_W-1:0]  WR_LAST    = WC_W'(BURST_SIZE - 1);

   state_t                state_q, state_d;
   grant_t                last_grant_q, last_grant_d;
   logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [WC_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNT_W-1:0]      ret_cnt_q, ret_cnt_d;

   always_ff @(posedge SDRAM_CLK or negedge nReset) begin
      if (!nReset) begin
         state_q      <= IDLE;
         last_grant_q <= GRANT_RD;
         wr_addr_q    <= '0;
         wr_cnt_q     <= '0;
         issue_cnt_q  <= '0;
         ret_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         wr_addr_q    <= wr_addr_d;
         wr_cnt_q     <= wr_cnt_d;
         issue_cnt_q  <= issue_cnt_d;
         ret_cnt_q    <= ret_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      wr_addr_d    = wr_addr_q;
      wr_cnt_d     = wr_cnt_q;
      issue_cnt_d  = issue_cnt_q;
      ret_cnt_d    = ret_cnt_q;
      avWrite_n    = 1'b1;
      avRead_n     = 1'b1;
      wrPop        = 1'b0;
      rdAddrAck    = 1'b0;
      avAddress    = '0;

      case (state_q)
         IDLE: begin
            // A write wins when it is alone or when the read went last.
            if (wrAvail && (!rdReq || last_grant_q == GRANT_RD)) begin
               state_d      = WRITE;
               wr_cnt_d     = '0;
               last_grant_d = GRANT_WR;
            end else if (rdReq) begin
               state_d      = RD_ISSUE;
               issue_cnt_d  = '0;
               ret_cnt_d    = '0;
               last_grant_d = GRANT_RD;
            end
         end
         WRITE: begin
            avAddress = wr_addr_q;
            avWrite_n = !wrAvail;
            if (!wrAvail) begin
               // FIFO ran dry: end the burst rather than idle on the bus.
               state_d = IDLE;
            end else if (!avWaitRequest) begin
               wrPop     = 1'b1;
               wr_addr_d = wr_addr_q + ADDR_WIDTH'(1);
               wr_cnt_d  = wr_cnt_q + WC_W'(1);
               if (wr_cnt_q == WR_LAST) begin
                  state_d = IDLE;
               end
            end
         end
         RD_ISSUE: begin
            avAddress = rdAddr;
            if (issue_cnt_q < BURST_C) begin
               avRead_n = 1'b0;
               if (!avWaitRequest) begin
                  rdAddrAck   = 1'b1;
                  issue_cnt_d = issue_cnt_q + CNT_W'(1);
                  if (issue_cnt_q == ISSUE_LAST) begin
                     state_d = RD_DRAIN;
                  end
               end
            end
         end
         RD_DRAIN: begin
            // Hold the bus until every issued read has come back.
            if (ret_cnt_q == BURST_C) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      // Returns are only ours while a read burst owns the port; anything
      // else (e.g. data in flight across a reset) is discarded.
      rdDataValid = avReadDataValid && (state_q == RD_ISSUE || state_q == RD_DRAIN);
      if (rdDataValid) begin
         ret_cnt_d = ret_cnt_q + CNT_W'(1);
      end

      // Frame start overrides any increment from a same-cycle write accept.
      if (frameStart) begin
         wr_addr_d = '0;
      end
   end

   assign rdData      = avReadData;
   assign avWriteData = wrData;

endmodule
